// File: rtl/tpu_accum_pkg.sv
// Shared constants and state encoding for the float8 vector accumulation sequencer.
package tpu_accum_pkg;

    localparam int TPU_LANES  = 32;
    localparam int TPU_LANE_W = 8;
    localparam int TPU_VEC_W  = TPU_LANES * TPU_LANE_W;

    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_LOAD,
        ACC_ACCUM,
        ACC_WAIT,
        ACC_OUT
    } acc_state_t;

endpackage

// File: rtl/tpu_accum_ctrl.sv
// Reduces N float8 vectors to one sum through an external combinational vector adder.
// TPU_ACCUM_PIPE_EN registers the adder's second operand and adds a WAIT state per add.
//
// state     | meaning
// ACC_IDLE  | waiting for start with a non-zero vector count
// ACC_LOAD  | first vector copied straight into the accumulator
// ACC_ACCUM | accept next vector (added directly, or captured into b_reg when pipelined)
// ACC_WAIT  | pipelined build only: accumulate b_reg through the adder
// ACC_OUT   | result held until the consumer takes it
module tpu_accum_ctrl
    import tpu_accum_pkg::*;
#(
    parameter int LANES  = TPU_LANES,
    parameter int LANE_W = TPU_LANE_W,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        vec_count,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    output logic [LANES*LANE_W-1:0] add_a,
    output logic [LANES*LANE_W-1:0] add_b,
    input  logic [LANES*LANE_W-1:0] add_sum,
    input  logic                    add_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    out_ovf
);

    localparam int VEC_W = LANES * LANE_W;

    acc_state_t       state, state_next;
    logic [VEC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] remaining, remaining_next, rem_dec;
    logic             ovf, ovf_next;
`ifdef TPU_ACCUM_PIPE_EN
    logic [VEC_W-1:0] b_reg, b_next;
`endif

    assign rem_dec = remaining - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC_IDLE;
            acc       <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
`ifdef TPU_ACCUM_PIPE_EN
            b_reg     <= '0;
`endif
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            remaining <= remaining_next;
            ovf       <= ovf_next;
`ifdef TPU_ACCUM_PIPE_EN
            b_reg     <= b_next;
`endif
        end
    end

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        remaining_next = remaining;
        ovf_next       = ovf;
`ifdef TPU_ACCUM_PIPE_EN
        b_next         = b_reg;
`endif
        case (state)
            ACC_IDLE: begin
                if (start && (vec_count != '0)) begin
                    state_next     = ACC_LOAD;
                    remaining_next = vec_count;
                    ovf_next       = 1'b0;
                end
            end
            ACC_LOAD: begin
                // First vector is copied, so the stale accumulator never reaches the sum.
                if (in_valid) begin
                    acc_next       = in_data;
                    remaining_next = rem_dec;
                    state_next     = (remaining == CNT_W'(1)) ? ACC_OUT : ACC_ACCUM;
                end
            end
            ACC_ACCUM: begin
                if (in_valid) begin
                    remaining_next = rem_dec;
`ifdef TPU_ACCUM_PIPE_EN
                    b_next         = in_data;
                    state_next     = ACC_WAIT;
`else
                    acc_next       = add_sum;
                    ovf_next       = ovf | add_ovf;
                    state_next     = (rem_dec == '0) ? ACC_OUT : ACC_ACCUM;
`endif
                end
            end
`ifdef TPU_ACCUM_PIPE_EN
            ACC_WAIT: begin
                acc_next   = add_sum;
                ovf_next   = ovf | add_ovf;
                state_next = (remaining == '0) ? ACC_OUT : ACC_ACCUM;
            end
`endif
            ACC_OUT: begin
                if (out_ready) begin
                    state_next = ACC_IDLE;
                end
            end
            default: begin
                state_next = ACC_IDLE;
            end
        endcase
    end

    assign busy      = (state != ACC_IDLE);
    assign in_ready  = (state == ACC_LOAD) || (state == ACC_ACCUM);
    assign out_valid = (state == ACC_OUT);
    assign out_data  = acc;
    assign out_ovf   = ovf;
    assign add_a     = acc;
`ifdef TPU_ACCUM_PIPE_EN
    assign add_b     = b_reg;
`else
    assign add_b     = in_data;
`endif

endmodule

// File: tb/tb_tpu_accum_ctrl.sv
// Scoreboard bench for tpu_accum_ctrl with a stand-in lane adder (8-bit wrap, carry as overflow).
module tb_tpu_accum_ctrl;
    import tpu_accum_pkg::*;

    localparam int LANES  = 32;
    localparam int LANE_W = 8;
    localparam int CNT_W  = 8;
    localparam int VEC_W  = LANES * LANE_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] vec_count = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [VEC_W-1:0] in_data = '0;
    logic [VEC_W-1:0] add_a, add_b, add_sum;
    logic             add_ovf;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [VEC_W-1:0] out_data;
    logic             out_ovf;

    tpu_accum_ctrl #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_count(vec_count), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_ovf(add_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in adder; force_on injects an overflow when the chosen vector is the operand.
    logic             force_on = 1'b0;
    logic [VEC_W-1:0] force_val = '0;
    logic [8:0]       lsum;
    logic             carry;
    always_comb begin
        add_sum = '0;
        carry   = 1'b0;
        lsum    = '0;
        for (int i = 0; i < LANES; i++) begin
            lsum = {1'b0, add_a[i*8 +: 8]} + {1'b0, add_b[i*8 +: 8]};
            add_sum[i*8 +: 8] = lsum[7:0];
            carry = carry | lsum[8];
        end
        add_ovf = carry | (force_on && (add_b == force_val));
    end

    typedef struct {
        logic [VEC_W-1:0] data;
        logic             ovf;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   start_cyc = 0;

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] r;
        for (int i = 0; i < VEC_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: pops expectations on output handshakes, checks hold stability during stalls.
    initial begin
        logic             prev_ov;
        logic             have_hold;
        logic [VEC_W-1:0] hold_d;
        logic             hold_o;
        int               lat_obs;
        exp_t             e;
        prev_ov = 1'b0; have_hold = 1'b0; hold_d = '0; hold_o = 1'b0; lat_obs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
                have_hold = 1'b0;
            end else begin
                if (out_valid && !prev_ov) lat_obs = cyc - start_cyc;
                if (out_valid && !out_ready) begin
                    if (have_hold) begin
                        check("hold_data", out_data, hold_d);
                        check("hold_ovf", VEC_W'(out_ovf), VEC_W'(hold_o));
                    end
                    have_hold = 1'b1;
                    hold_d = out_data;
                    hold_o = out_ovf;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %h want none", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_ovf", VEC_W'(out_ovf), VEC_W'(e.ovf));
                        if (e.lat >= 0) check("latency", VEC_W'(lat_obs), VEC_W'(e.lat));
                    end
                    have_hold = 1'b0;
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want progress", name);
    endtask

    // One reduction: reference = per-lane integer totals; overflow iff any lane total exceeds 255.
    task automatic run(input int n, input bit stall_in, input int max_val, input bit force_ovf,
                       input bit glitch, input int out_stall, input int fixed);
        logic [VEC_W-1:0] v[$];
        logic [VEC_W-1:0] w;
        int   tot[LANES];
        exp_t e;
        int   guard;
        bit   hs;
        for (int l = 0; l < LANES; l++) tot[l] = 0;
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < LANES; l++) begin
                w[l*8 +: 8] = (fixed >= 0) ? 8'(fixed) : 8'($urandom_range(0, max_val));
                tot[l] += int'(w[l*8 +: 8]);
            end
            v.push_back(w);
        end
        e.ovf = force_ovf;
        for (int l = 0; l < LANES; l++) begin
            e.data[l*8 +: 8] = 8'(tot[l] % 256);
            if (tot[l] > 255) e.ovf = 1'b1;
        end
`ifdef TPU_ACCUM_PIPE_EN
        e.lat = stall_in ? -1 : 2 * n;
`else
        e.lat = stall_in ? -1 : n + 1;
`endif
        if (force_ovf && n >= 3) begin
            force_val = v[2];
            force_on = 1'b1;
        end
        sb.push_back(e);
        out_ready = (out_stall == 0);
        start = 1'b1;
        vec_count = CNT_W'(n);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        vec_count = CNT_W'($urandom);
        for (int k = 0; k < n; k++) begin
            guard = 0;
            do begin
                in_valid = stall_in ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data = in_valid ? v[k] : rand_vec();
                if (glitch && k == 2) begin
                    start = 1'b1;
                    vec_count = CNT_W'(5);
                end
                hs = in_valid && in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                guard++;
            end while (!hs && guard < 100);
            if (!hs) timeout_fail("input_handshake");
        end
        in_valid = 1'b0;
        in_data = rand_vec();
        if (out_stall > 0) begin
            guard = 0;
            while (!out_valid && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (!out_valid) timeout_fail("out_valid_wait");
            repeat (out_stall) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            start = 1'b1;
            vec_count = CNT_W'(3);
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_out_hs_ignored", VEC_W'(busy), VEC_W'(0));
        end
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            timeout_fail("result_drain");
            sb.delete();
        end
        force_on = 1'b0;
        check("idle_after_run", VEC_W'(busy), VEC_W'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, VEC_W'(busy), VEC_W'(0));
        check({tag, "_in_ready"}, VEC_W'(in_ready), VEC_W'(0));
        check({tag, "_out_valid"}, VEC_W'(out_valid), VEC_W'(0));
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_out_ovf"}, VEC_W'(out_ovf), VEC_W'(0));
        check({tag, "_add_a"}, add_a, '0);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got no finish want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(1, 0, 255, 0, 0, 0, 8'h3C);
        for (int i = 0; i < 3; i++) run(4, 0, 255, 0, 0, 0, -1);
        run(4, 0, 60, 0, 0, 0, -1);
        run(3, 1, 255, 0, 0, 5, -1);
        run(3, 0, 50, 1, 0, 0, -1);
        run(3, 0, 50, 0, 0, 0, -1);

        start = 1'b1;
        vec_count = '0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("zero_count_busy", VEC_W'(busy), VEC_W'(0));
            @(posedge clk); #1;
        end

        run(4, 0, 255, 0, 1, 0, -1);

        start = 1'b1;
        vec_count = CNT_W'(8);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data = rand_vec();
            @(posedge clk); #1;
        end
        check("midrun_busy", VEC_W'(busy), VEC_W'(1));
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(2, 0, 255, 0, 0, 0, -1);

        for (int i = 0; i < 6; i++) begin
            run($urandom_range(1, 10), 1'($urandom_range(0, 1)), 40, 0, 0,
                $urandom_range(0, 3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
